// File: rtl/text_pkg.sv
// Shared constants and types for the team-name text path: HID keycodes
// of interest, the blank glyph code, and the name-entry state encoding.
package text_pkg;

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_Z     = 8'h1D;
    localparam logic [7:0] KC_1     = 8'h1E;
    localparam logic [7:0] KC_0     = 8'h27;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_BKSP  = 8'h2A;
    localparam logic [7:0] KC_ENTER = 8'h28;

    localparam logic [6:0] ASCII_BLANK = 7'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ENTRY = 2'd2,
        DONE  = 2'd3
    } entry_state_t;

endpackage

// File: rtl/hid_to_ascii.sv
// Combinational HID keycode decoder: letters, digits and space become
// 7-bit ASCII; backspace and enter are flagged; everything else decodes
// to "nothing".
module hid_to_ascii
    import text_pkg::*;
(
    input  logic [7:0] keycode,
    output logic [6:0] ascii,
    output logic       printable,
    output logic       is_bksp,
    output logic       is_enter
);

    // Range decode of printable keycodes into ASCII.
    always_comb begin
        ascii     = 7'h00;
        printable = 1'b0;
        if (keycode >= KC_A && keycode <= KC_Z) begin
            ascii     = 7'h41 + 7'(keycode - KC_A);
            printable = 1'b1;
        end else if (keycode >= KC_1 && keycode < KC_0) begin
            // '1'..'9' precede '0' in HID order, unlike ASCII
            ascii     = 7'h31 + 7'(keycode - KC_1);
            printable = 1'b1;
        end else if (keycode == KC_0) begin
            ascii     = 7'h30;
            printable = 1'b1;
        end else if (keycode == KC_SPACE) begin
            ascii     = 7'h20;
            printable = 1'b1;
        end
    end

    assign is_bksp  = (keycode == KC_BKSP);
    assign is_enter = (keycode == KC_ENTER);

endmodule

// File: rtl/team_name_entry.sv
// Team-name entry controller: turns key presses into single-cycle writes
// on the name register's write port, with clear, backspace and enter.
module team_name_entry
    import text_pkg::*;
#(
    parameter int         NAME_LEN = 7,
    parameter int         ADDR_W   = 3,
    parameter logic [6:0] BLANK    = ASCII_BLANK
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic              start,
    output logic [6:0]        team_in,
    output logic [ADDR_W-1:0] team_addr,
    output logic              we,
    output logic [ADDR_W:0]   cursor,
    output logic              entering,
    output logic              name_done
);

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NAME_LEN - 1);
    localparam logic [ADDR_W:0]   LEN_C     = (ADDR_W + 1)'(NAME_LEN);

    entry_state_t      state;
    logic [ADDR_W-1:0] clr_idx;
    logic [7:0]        prev_key;

    logic [6:0] ascii;
    logic       printable;
    logic       is_bksp;
    logic       is_enter;
    logic       press;

    hid_to_ascii u_map (
        .keycode   (keycode),
        .ascii     (ascii),
        .printable (printable),
        .is_bksp   (is_bksp),
        .is_enter  (is_enter)
    );

    // A press is an edge to a new nonzero code; holding never repeats.
    assign press = (keycode != prev_key) && (keycode != 8'h00);

    // Entry FSM with registered write port, cursor and status flags.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            clr_idx   <= '0;
            prev_key  <= 8'h00;
            team_in   <= 7'h00;
            team_addr <= '0;
            we        <= 1'b0;
            cursor    <= '0;
            entering  <= 1'b0;
            name_done <= 1'b0;
        end else begin
            prev_key <= keycode;
            we       <= 1'b0;
            if (start) begin
                // start outranks any press and restarts the clear sweep
                state     <= CLEAR;
                clr_idx   <= '0;
                cursor    <= '0;
                entering  <= 1'b0;
                name_done <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    CLEAR: begin
                        we        <= 1'b1;
                        team_addr <= clr_idx;
                        team_in   <= BLANK;
                        if (clr_idx == LAST_SLOT) begin
                            state    <= ENTRY;
                            entering <= 1'b1;
                            cursor   <= '0;
                        end else begin
                            clr_idx <= clr_idx + 1'b1;
                        end
                    end
                    ENTRY: begin
                        if (press) begin
                            if (printable && cursor < LEN_C) begin
                                we        <= 1'b1;
                                team_addr <= cursor[ADDR_W-1:0];
                                team_in   <= ascii;
                                cursor    <= cursor + 1'b1;
                            end else if (is_bksp && cursor != '0) begin
                                we        <= 1'b1;
                                team_addr <= ADDR_W'(cursor - 1'b1);
                                team_in   <= BLANK;
                                cursor    <= cursor - 1'b1;
                            end else if (is_enter && cursor != '0) begin
                                state     <= DONE;
                                entering  <= 1'b0;
                                name_done <= 1'b1;
                            end
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
